// File: rtl/scm_mc.sv
// Multi-channel statistics module: registered metadata/PHV pass-through plus CH_NUM windowed
// packet/byte counters reporting over the 134-bit control path.
//
// state | meaning
// IDLE  | channel disarmed, counters clear, waiting for start with enable set
// CNT   | window open, matching metadata accumulates into pkt/byte
// WAIT  | window closed, comparing byte count against threshold
// FETCH | report requested, waiting for output grant
module scm_mc #(
  parameter int MD_W   = 256,
  parameter int PHV_W  = 1024,
  parameter int CH_NUM = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [MD_W-1:0]   in_scm_md,
  input  logic              in_scm_md_wr,
  output logic              out_scm_md_alf,
  input  logic [PHV_W-1:0]  in_scm_phv,
  input  logic              in_scm_phv_wr,
  output logic              out_scm_phv_alf,
  output logic [MD_W-1:0]   out_scm_md,
  output logic              out_scm_md_wr,
  input  logic              in_scm_md_alf,
  output logic [PHV_W-1:0]  out_scm_phv,
  output logic              out_scm_phv_wr,
  input  logic              in_scm_phv_alf,
  input  logic [CH_NUM-1:0] gac2scm_sent_start,
  input  logic [CH_NUM-1:0] gac2scm_sent_end,
  input  logic [133:0]      cin_scm_data,
  input  logic              cin_scm_data_wr,
  output logic              cout_scm_ready,
  output logic [133:0]      cout_scm_data,
  output logic              cout_scm_data_wr,
  input  logic              cin_scm_ready
);
  localparam int ACC_W = ((CNT_W > 32) ? CNT_W : 32) + 1;
  localparam int PAD_W = 134 - 14 - 2 * CNT_W;

  typedef enum logic [1:0] {IDLE, CNT, WAIT, FETCH} ch_st_t;

  ch_st_t             st      [CH_NUM];
  ch_st_t             st_nxt  [CH_NUM];
  logic [7:0]         key     [CH_NUM];
  logic               en      [CH_NUM];
  logic [CNT_W-1:0]   thr     [CH_NUM];
  logic [CNT_W-1:0]   pkt     [CH_NUM];
  logic [CNT_W-1:0]   pkt_nxt [CH_NUM];
  logic [CNT_W-1:0]   byt     [CH_NUM];
  logic [CNT_W-1:0]   byt_nxt [CH_NUM];

  logic               rd_pend;
  logic [133:0]       rd_word;
  logic [3:0]         last_ch;

  logic               cin_acc, ch_ok, cfg_wr, cfg_rd;
  logic [3:0]         c_op, c_ch, c_reg;
  logic [63:0]        c_data, rd_data;

  logic               gnt_rd, rr_found;
  logic [CH_NUM-1:0]  gnt_ch;
  logic [3:0]         gnt_idx;
  logic [133:0]       rpt_word;
  int                 rr_idx;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [31:0] b);
    logic [ACC_W-1:0] s;
    s = ACC_W'(a) + ACC_W'(b);
    if (s > ACC_W'({CNT_W{1'b1}})) return '1;
    return s[CNT_W-1:0];
  endfunction

  assign out_scm_md_alf  = in_scm_md_alf;
  assign out_scm_phv_alf = in_scm_phv_alf;
  assign cout_scm_ready  = ~rd_pend;

  assign cin_acc = cin_scm_data_wr & cout_scm_ready;
  assign c_op    = cin_scm_data[127:124];
  assign c_ch    = cin_scm_data[71:68];
  assign c_reg   = cin_scm_data[67:64];
  assign c_data  = cin_scm_data[63:0];
  assign ch_ok   = (int'(c_ch) < CH_NUM);
  assign cfg_wr  = cin_acc & ch_ok & (c_op == 4'hA);
  assign cfg_rd  = cin_acc & ch_ok & (c_op == 4'h9);

  always_comb begin
    rd_data = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      if (int'(c_ch) == c) begin
        case (c_reg)
          4'd0:    rd_data = 64'(key[c]);
          4'd1:    rd_data = 64'(en[c]);
          4'd2:    rd_data = 64'(thr[c]);
          4'd3:    rd_data = 64'({pkt[c], byt[c]});
          default: rd_data = '0;
        endcase
      end
    end
  end

  // A pending read response always wins; otherwise rotate from the channel after the last grant.
  always_comb begin
    gnt_rd   = 1'b0;
    gnt_ch   = '0;
    gnt_idx  = last_ch;
    rpt_word = '0;
    rr_idx   = 0;
    rr_found = 1'b0;
    if (cin_scm_ready) begin
      if (rd_pend) begin
        gnt_rd = 1'b1;
      end else begin
        for (int i = 1; i <= CH_NUM; i++) begin
          rr_idx = (int'(last_ch) + i) % CH_NUM;
          if (!rr_found && st[rr_idx] == FETCH) begin
            rr_found       = 1'b1;
            gnt_ch[rr_idx] = 1'b1;
            gnt_idx        = 4'(rr_idx);
            rpt_word       = {6'b010000, 4'hB, 4'(rr_idx), pkt[rr_idx], byt[rr_idx], {PAD_W{1'b0}}};
          end
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < CH_NUM; c++) begin
      st_nxt[c]  = st[c];
      pkt_nxt[c] = pkt[c];
      byt_nxt[c] = byt[c];
      case (st[c])
        IDLE: begin
          if (gac2scm_sent_start[c] && en[c]) begin
            st_nxt[c]  = CNT;
            pkt_nxt[c] = '0;
            byt_nxt[c] = '0;
          end
        end
        CNT: begin
          if (in_scm_md_wr && in_scm_md[79:72] == key[c]) begin
            pkt_nxt[c] = sat_add(pkt[c], 32'd1);
            byt_nxt[c] = sat_add(byt[c], in_scm_md[31:0]);
          end
          if (gac2scm_sent_end[c]) st_nxt[c] = WAIT;
        end
        WAIT: begin
          if (byt[c] >= thr[c])           st_nxt[c] = FETCH;
          else if (gac2scm_sent_start[c]) st_nxt[c] = CNT;
        end
        FETCH: begin
          if (gnt_ch[c]) begin
            st_nxt[c]  = IDLE;
            pkt_nxt[c] = '0;
            byt_nxt[c] = '0;
          end
        end
        default: st_nxt[c] = IDLE;
      endcase
      // Disabling a channel aborts whatever it was doing.
      if (cfg_wr && c_reg == 4'd1 && int'(c_ch) == c && !c_data[0]) begin
        st_nxt[c]  = IDLE;
        pkt_nxt[c] = '0;
        byt_nxt[c] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CH_NUM; c++) begin
        st[c]  <= IDLE;
        key[c] <= '0;
        en[c]  <= 1'b0;
        thr[c] <= '0;
        pkt[c] <= '0;
        byt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CH_NUM; c++) begin
        st[c]  <= st_nxt[c];
        pkt[c] <= pkt_nxt[c];
        byt[c] <= byt_nxt[c];
        if (cfg_wr && int'(c_ch) == c) begin
          case (c_reg)
            4'd0:    key[c] <= c_data[7:0];
            4'd1:    en[c]  <= c_data[0];
            4'd2:    thr[c] <= c_data[CNT_W-1:0];
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_scm_md       <= '0;
      out_scm_md_wr    <= 1'b0;
      out_scm_phv      <= '0;
      out_scm_phv_wr   <= 1'b0;
      cout_scm_data    <= '0;
      cout_scm_data_wr <= 1'b0;
      rd_pend          <= 1'b0;
      rd_word          <= '0;
      last_ch          <= 4'(CH_NUM - 1);
    end else begin
      out_scm_md       <= in_scm_md;
      out_scm_md_wr    <= in_scm_md_wr;
      out_scm_phv      <= in_scm_phv;
      out_scm_phv_wr   <= in_scm_phv_wr;
      cout_scm_data_wr <= 1'b0;
      if (gnt_rd) begin
        cout_scm_data    <= rd_word;
        cout_scm_data_wr <= 1'b1;
        rd_pend          <= 1'b0;
      end else if (rr_found) begin
        cout_scm_data    <= rpt_word;
        cout_scm_data_wr <= 1'b1;
        last_ch          <= gnt_idx;
      end
      if (cfg_rd) begin
        rd_pend <= 1'b1;
        rd_word <= {6'b010000, 4'h9, 52'b0, c_ch, c_reg, rd_data};
      end
    end
  end
endmodule

// File: tb/tb_scm_mc.sv
// Directed bench for scm_mc: table-driven pass-through and config vectors, then hand-written
// window, threshold, arbitration, read-priority and saturation/reset sequences.
module tb_scm_mc;
  logic          clk = 1'b0;
  logic          rst;
  logic [255:0]  in_scm_md;
  logic          in_scm_md_wr;
  logic          out_scm_md_alf;
  logic [1023:0] in_scm_phv;
  logic          in_scm_phv_wr;
  logic          out_scm_phv_alf;
  logic [255:0]  out_scm_md;
  logic          out_scm_md_wr;
  logic          in_scm_md_alf;
  logic [1023:0] out_scm_phv;
  logic          out_scm_phv_wr;
  logic          in_scm_phv_alf;
  logic [3:0]    gac2scm_sent_start;
  logic [3:0]    gac2scm_sent_end;
  logic [133:0]  cin_scm_data;
  logic          cin_scm_data_wr;
  logic          cout_scm_ready;
  logic [133:0]  cout_scm_data;
  logic          cout_scm_data_wr;
  logic          cin_scm_ready;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  scm_mc dut (
    .clk(clk), .rst(rst),
    .in_scm_md(in_scm_md), .in_scm_md_wr(in_scm_md_wr), .out_scm_md_alf(out_scm_md_alf),
    .in_scm_phv(in_scm_phv), .in_scm_phv_wr(in_scm_phv_wr), .out_scm_phv_alf(out_scm_phv_alf),
    .out_scm_md(out_scm_md), .out_scm_md_wr(out_scm_md_wr), .in_scm_md_alf(in_scm_md_alf),
    .out_scm_phv(out_scm_phv), .out_scm_phv_wr(out_scm_phv_wr), .in_scm_phv_alf(in_scm_phv_alf),
    .gac2scm_sent_start(gac2scm_sent_start), .gac2scm_sent_end(gac2scm_sent_end),
    .cin_scm_data(cin_scm_data), .cin_scm_data_wr(cin_scm_data_wr),
    .cout_scm_ready(cout_scm_ready), .cout_scm_data(cout_scm_data),
    .cout_scm_data_wr(cout_scm_data_wr), .cin_scm_ready(cin_scm_ready)
  );

  typedef struct {
    logic [31:0] md_seed;
    logic [31:0] phv_seed;
    logic        md_wr;
    logic        phv_wr;
    logic        md_alf;
    logic        phv_alf;
    logic [31:0] e_md_seed;
    logic [31:0] e_phv_seed;
    logic        e_md_wr;
    logic        e_phv_wr;
    logic        e_md_alf;
    logic        e_phv_alf;
  } pt_vec_t;

  typedef struct {
    logic [3:0]  ch;
    logic [3:0]  rg;
    logic [63:0] wdata;
    logic [63:0] e_rdata;
  } cfg_vec_t;

  function automatic logic [133:0] cw(input logic [3:0] op, input logic [3:0] ch,
                                      input logic [3:0] rg, input logic [63:0] d);
    return {6'b000001, op, 52'b0, ch, rg, d};
  endfunction

  function automatic logic [133:0] rsp(input logic [3:0] ch, input logic [3:0] rg, input logic [63:0] d);
    return {6'b010000, 4'h9, 52'b0, ch, rg, d};
  endfunction

  function automatic logic [133:0] rpt(input logic [3:0] ch, input logic [31:0] p, input logic [31:0] b);
    return {6'b010000, 4'hB, ch, p, b, 56'b0};
  endfunction

  task automatic chk(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act[139:0], exp[139:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ctl(input logic [3:0] op, input logic [3:0] ch, input logic [3:0] rg, input logic [63:0] d);
    cin_scm_data    = cw(op, ch, rg, d);
    cin_scm_data_wr = 1'b1;
    tick();
    cin_scm_data_wr = 1'b0;
  endtask

  task automatic send_md(input logic [7:0] k, input logic [31:0] len);
    in_scm_md        = '0;
    in_scm_md[79:72] = k;
    in_scm_md[31:0]  = len;
    in_scm_md_wr     = 1'b1;
    tick();
    in_scm_md_wr     = 1'b0;
  endtask

  task automatic pulse_start(input logic [3:0] m);
    gac2scm_sent_start = m;
    tick();
    gac2scm_sent_start = '0;
  endtask

  task automatic pulse_end(input logic [3:0] m);
    gac2scm_sent_end = m;
    tick();
    gac2scm_sent_end = '0;
  endtask

  task automatic wait_word(input string nm, input logic [133:0] exp, input int max);
    bit got = 1'b0;
    for (int i = 0; i < max && !got; i++) begin
      tick();
      if (cout_scm_data_wr) got = 1'b1;
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: no output word within %0d cycles, expected %h", nm, max, exp);
    end else begin
      chk(nm, 1024'(cout_scm_data), 1024'(exp));
    end
  endtask

  task automatic no_word(input string nm, input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (cout_scm_data_wr) seen++;
    end
    chk(nm, 1024'(seen), 1024'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  pt_vec_t  pt_tab  [5];
  cfg_vec_t cfg_tab [5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pt_tab[0] = '{32'h11111111, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b0, 1'b1, 32'h11111111, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b0, 1'b1};
    pt_tab[1] = '{32'h22223333, 32'h5A5A0000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h22223333, 32'h5A5A0000, 1'b1, 1'b0, 1'b1, 1'b0};
    pt_tab[2] = '{32'hDEADBEEF, 32'h01234567, 1'b0, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 32'h01234567, 1'b0, 1'b1, 1'b1, 1'b1};
    pt_tab[3] = '{32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    pt_tab[4] = '{32'hCAFEF00D, 32'h80000001, 1'b0, 1'b0, 1'b1, 1'b0, 32'hCAFEF00D, 32'h80000001, 1'b0, 1'b0, 1'b1, 1'b0};

    cfg_tab[0] = '{4'd0, 4'd0, 64'h1FF,                 64'hFF};
    cfg_tab[1] = '{4'd1, 4'd1, 64'h3,                   64'h1};
    cfg_tab[2] = '{4'd2, 4'd2, 64'hDEADBEEF_12345678,   64'h12345678};
    cfg_tab[3] = '{4'd3, 4'd0, 64'hAB,                  64'hAB};
    cfg_tab[4] = '{4'd0, 4'd3, 64'h777,                 64'h0};

    rst = 1'b1;
    in_scm_md = '0; in_scm_md_wr = 1'b0; in_scm_phv = '0; in_scm_phv_wr = 1'b0;
    in_scm_md_alf = 1'b0; in_scm_phv_alf = 1'b0;
    gac2scm_sent_start = '0; gac2scm_sent_end = '0;
    cin_scm_data = '0; cin_scm_data_wr = 1'b0; cin_scm_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_cout_ready", 1024'(cout_scm_ready), 1024'(1'b1));
    chk("rst_cout_wr", 1024'(cout_scm_data_wr), 1024'(1'b0));
    chk("rst_cout_data", 1024'(cout_scm_data), 1024'(0));
    chk("rst_out_md_wr", 1024'({out_scm_md_wr, out_scm_phv_wr}), 1024'(0));

    // pass-through table
    for (int i = 0; i < 5; i++) begin
      in_scm_md      = {8{pt_tab[i].md_seed}};
      in_scm_phv     = {32{pt_tab[i].phv_seed}};
      in_scm_md_wr   = pt_tab[i].md_wr;
      in_scm_phv_wr  = pt_tab[i].phv_wr;
      in_scm_md_alf  = pt_tab[i].md_alf;
      in_scm_phv_alf = pt_tab[i].phv_alf;
      #1;
      chk($sformatf("pt%0d_alf", i), 1024'({out_scm_md_alf, out_scm_phv_alf}),
          1024'({pt_tab[i].e_md_alf, pt_tab[i].e_phv_alf}));
      tick();
      chk($sformatf("pt%0d_md", i), 1024'(out_scm_md), 1024'({8{pt_tab[i].e_md_seed}}));
      chk($sformatf("pt%0d_phv", i), out_scm_phv, {32{pt_tab[i].e_phv_seed}});
      chk($sformatf("pt%0d_wr", i), 1024'({out_scm_md_wr, out_scm_phv_wr}),
          1024'({pt_tab[i].e_md_wr, pt_tab[i].e_phv_wr}));
    end
    in_scm_md_wr = 1'b0; in_scm_phv_wr = 1'b0; in_scm_md_alf = 1'b0; in_scm_phv_alf = 1'b0;

    // config write / readback table
    for (int i = 0; i < 5; i++) begin
      do_ctl(4'hA, cfg_tab[i].ch, cfg_tab[i].rg, cfg_tab[i].wdata);
      do_ctl(4'h9, cfg_tab[i].ch, cfg_tab[i].rg, 64'h0);
      wait_word($sformatf("cfg%0d_rd", i), rsp(cfg_tab[i].ch, cfg_tab[i].rg, cfg_tab[i].e_rdata), 4);
    end
    do_ctl(4'h3, 4'd3, 4'd0, 64'h11);
    do_ctl(4'h9, 4'd3, 4'd0, 64'h0);
    wait_word("bad_op_ignored", rsp(4'd3, 4'd0, 64'hAB), 4);
    do_ctl(4'h9, 4'd5, 4'd0, 64'h0);
    chk("bad_ch_ready", 1024'(cout_scm_ready), 1024'(1'b1));
    no_word("bad_ch_no_rsp", 3);

    // window count
    do_reset();
    do_ctl(4'hA, 4'd0, 4'd0, 64'h82);
    do_ctl(4'hA, 4'd0, 4'd1, 64'h1);
    do_ctl(4'hA, 4'd0, 4'd2, 64'h30);
    pulse_start(4'b0001);
    send_md(8'h82, 32'h10);
    send_md(8'h82, 32'h10);
    send_md(8'h83, 32'h10);
    send_md(8'h82, 32'h10);
    pulse_end(4'b0001);
    wait_word("win_report", rpt(4'd0, 32'd3, 32'h30), 6);
    no_word("win_single", 3);
    do_ctl(4'h9, 4'd0, 4'd3, 64'h0);
    wait_word("win_cleared", rsp(4'd0, 4'd3, 64'h0), 4);
    pulse_end(4'b0001);
    no_word("end_in_idle", 4);

    // below threshold, accumulate across two windows
    do_ctl(4'hA, 4'd0, 4'd2, 64'h80);
    pulse_start(4'b0001);
    send_md(8'h82, 32'h10);
    pulse_end(4'b0001);
    no_word("below_thr", 6);
    pulse_start(4'b0001);
    send_md(8'h82, 32'h80);
    pulse_end(4'b0001);
    wait_word("thr_report", rpt(4'd0, 32'd2, 32'h90), 6);

    // arbitration with a ready gap
    do_reset();
    for (int c = 0; c < 4; c++) begin
      do_ctl(4'hA, 4'(c), 4'd0, 64'h82);
      do_ctl(4'hA, 4'(c), 4'd1, 64'h1);
    end
    pulse_start(4'hF);
    send_md(8'h82, 32'h1);
    pulse_end(4'hF);
    wait_word("arb_ch0", rpt(4'd0, 32'd1, 32'd1), 5);
    tick();
    chk("arb_ch1", 1024'({cout_scm_data_wr, cout_scm_data}), 1024'({1'b1, rpt(4'd1, 32'd1, 32'd1)}));
    cin_scm_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("arb_stall%0d", i), 1024'(cout_scm_data_wr), 1024'(1'b0));
    end
    cin_scm_ready = 1'b1;
    tick();
    chk("arb_ch2", 1024'({cout_scm_data_wr, cout_scm_data}), 1024'({1'b1, rpt(4'd2, 32'd1, 32'd1)}));
    tick();
    chk("arb_ch3", 1024'({cout_scm_data_wr, cout_scm_data}), 1024'({1'b1, rpt(4'd3, 32'd1, 32'd1)}));
    tick();
    chk("arb_done", 1024'(cout_scm_data_wr), 1024'(1'b0));

    // read response beats a pending report
    cin_scm_ready = 1'b0;
    do_ctl(4'hA, 4'd1, 4'd2, 64'h1234);
    pulse_start(4'b0100);
    pulse_end(4'b0100);
    tick();
    tick();
    do_ctl(4'h9, 4'd1, 4'd2, 64'h0);
    chk("rd_not_ready", 1024'(cout_scm_ready), 1024'(1'b0));
    tick();
    tick();
    chk("rd_held", 1024'({cout_scm_data_wr, cout_scm_ready}), 1024'(2'b00));
    cin_scm_ready = 1'b1;
    tick();
    chk("rd_first", 1024'({cout_scm_data_wr, cout_scm_data}), 1024'({1'b1, rsp(4'd1, 4'd2, 64'h1234)}));
    chk("rd_ready_back", 1024'(cout_scm_ready), 1024'(1'b1));
    tick();
    chk("rd_then_rpt", 1024'({cout_scm_data_wr, cout_scm_data}), 1024'({1'b1, rpt(4'd2, 32'd0, 32'd0)}));

    // saturation, then reset mid-window with a pending read
    do_ctl(4'hA, 4'd3, 4'd2, 64'hFFFFFFFF);
    pulse_start(4'b1000);
    send_md(8'h82, 32'hFFFFFFFF);
    send_md(8'h82, 32'hFFFFFFFF);
    do_ctl(4'h9, 4'd3, 4'd3, 64'h0);
    wait_word("sat_read", rsp(4'd3, 4'd3, {32'd2, 32'hFFFFFFFF}), 4);
    pulse_end(4'b1000);
    wait_word("sat_report", rpt(4'd3, 32'd2, 32'hFFFFFFFF), 6);
    pulse_start(4'b1000);
    send_md(8'h82, 32'h5);
    cin_scm_ready = 1'b0;
    do_ctl(4'h9, 4'd0, 4'd0, 64'h0);
    chk("pre_rst_pending", 1024'(cout_scm_ready), 1024'(1'b0));
    in_scm_md    = {8{32'h5A5A5A5A}};
    in_scm_md_wr = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_scm_md_wr = 1'b0;
    chk("mid_rst_ready", 1024'(cout_scm_ready), 1024'(1'b1));
    chk("mid_rst_cout", 1024'({cout_scm_data_wr, cout_scm_data}), 1024'(0));
    chk("mid_rst_md", 1024'({out_scm_md_wr, out_scm_md}), 1024'(0));
    cin_scm_ready = 1'b1;
    no_word("mid_rst_dropped", 4);
    do_ctl(4'h9, 4'd3, 4'd1, 64'h0);
    wait_word("mid_rst_en", rsp(4'd3, 4'd1, 64'h0), 4);
    do_ctl(4'h9, 4'd3, 4'd3, 64'h0);
    wait_word("mid_rst_cnt", rsp(4'd3, 4'd3, 64'h0), 4);
    pulse_end(4'b1000);
    no_word("mid_rst_idle", 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
